sram_access_arbiter: RTL and testbench
======================================

# sram_access_arbiter

Arbitrates between the PE read-request channel and the PE write-back channel in front of the single-port SRAM controller. It buffers write-back words in a small FIFO and enforces the controller's read-slot spacing. It regenerates the controller's unflagged read data as a valid-qualified stream and sequences end-of-pass flushes before the read/write address reset. It sits between the DataProcessor and the SRAM controller; the controller's ports are driven only by this block.

## Interface
- `WORD`, `` `Sram_Word `` (256): data word width.
- `FIFO_DEPTH`, 4: write-back FIFO entries, power of two.
- `RD_LAT`, 3: cycles from `o_PE_request` high to controller data valid.
- `RD_GAP`, 4: minimum cycles between a read issue and the next controller access of any kind.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rd_req` in 1: PE wants one read word.
- `rd_ready` out 1: read accepted when `rd_req & rd_ready`.
- `rd_valid` out 1: `rd_data` valid this cycle.
- `rd_data` out WORD: returned word.
- `wr_valid` in 1: write-back word offered.
- `wr_data` in WORD: write-back word.
- `wr_ready` out 1: write accepted when `wr_valid & wr_ready`.
- `flush_req` in 1: pulse, end of pass.
- `flush_done` out 1: one-cycle pulse when the flush completes.
- `i_busy` in 1: controller busy (init/T load); no accesses are issued while high.
- `i_request_data` in WORD: controller read data.
- `o_PE_request` out 1: controller read strobe.
- `o_PE_send` out 1: controller write strobe.
- `o_send_data` out WORD: controller write data.
- `o_rst_addr` out 1: controller address-reset strobe.

## Operation
- States: RUN, FLUSH, RSTA. Reset to RUN.
- Write FIFO (depth `FIFO_DEPTH`):
  - Push on `wr_valid & wr_ready`.
  - `wr_ready = !full & state==RUN`.
  - Simultaneous push and pop is legal when full, but `wr_ready` still reflects the registered full flag.
- Gap counter `gap`: loaded with `RD_GAP-1` when a read issues, decrements to 0. No controller access is issued while `gap != 0` or `i_busy`.
- Arbitration, per slot (`gap==0 & !i_busy`). First match wins:
  1. FIFO full → write.
  2. `turn==WR` and FIFO not empty → write.
  3. `rd_req` and state RUN → read.
  4. FIFO not empty → write.
- `turn` becomes WR after a read issue and RD after a write issue. This guarantees alternation under contention.
- `rd_ready` is the combinational result "read wins this slot".
- Read issue: `o_PE_request` is registered high for exactly one cycle, in the cycle after acceptance.
- Write issue: `o_PE_send` is registered high for one cycle with `o_send_data` equal to the FIFO head. Pop occurs at issue.
- Back-to-back writes may issue every cycle.
- `o_PE_request` and `o_PE_send` are never high in the same cycle.
- Read return: an `RD_LAT`-deep valid shift register is fed by `o_PE_request`. When its output is high, `rd_valid` is high and `rd_data` equals `i_request_data`. Both are combinational from the shift-register tap.
- Flush sequence:
  - `flush_req` in RUN → FLUSH. Reads are blocked and writes are no longer accepted.
  - FLUSH ends when the FIFO is empty, `gap==0` and no read is outstanding in the shift register. The block then goes to RSTA.
  - RSTA: `o_rst_addr` and `flush_done` are each high for one cycle, then the state returns to RUN.
  - `flush_req` outside RUN is ignored.
- `i_busy` high during FLUSH stalls the drain. The FIFO contents are kept.

## Timing
- Reset values: `rd_ready`=0 (combinational, forced by `i_busy`/state), `rd_valid`=0, `rd_data`=0, `wr_ready`=1, `flush_done`=0, `o_PE_request`=0, `o_PE_send`=0, `o_send_data`=0, `o_rst_addr`=0.
- Internal reset values: FIFO empty, `gap`=0, `turn`=RD, shift register cleared.
- Read accepted at cycle t:
  - `o_PE_request` is high at t+1 and `rd_valid` is high at t+1+`RD_LAT` (t+4 by default).
  - The next access of any kind issues no earlier than t+1+`RD_GAP`.
- Write pushed into an empty FIFO at cycle t, with an idle slot: `o_PE_send` is high at t+1.
- Reset mid-operation: all buffered writes and outstanding reads are discarded, with no `rd_valid` afterward. Re-initialising the SRAM controller is the system's job.

## Structure
- The shared defines header owns `Sram_Word`, `RD_LAT`/`RD_GAP` defaults and the state encodings.
- Sub-module `sram_wr_fifo`: a synchronous FIFO with full/empty flags, 2-bit pointers plus a wrap bit. The arbiter, counters and shift register stay in the top module.

## Test plan
- Read alone: `rd_req` held high with FIFO empty → one `o_PE_request` every 4 cycles. `rd_valid` follows each issue 3 cycles later with `rd_data = i_request_data`.
- Write burst: 4 writes pushed with no reads pending → `o_PE_send` on 4 consecutive cycles carrying the words in order. `wr_ready` drops only while full.
- Contention: `rd_req` held high and the FIFO kept non-empty → reads and writes alternate. The strobes never overlap, and no access falls within 3 cycles after a read.
- Full priority: FIFO full with `turn==RD` and `rd_req` high → a write issues first and `rd_ready` stays 0 that slot.
- Flush:
  - Setup: 3 writes queued plus 1 outstanding read, then `flush_req`.
  - Writes drain and `rd_valid` still arrives.
  - Then `o_rst_addr` and `flush_done` pulse together once, with `wr_ready` and `rd_ready` held at 0 throughout.
- Busy/reset: `i_busy` high for 10 cycles with writes queued → no strobes, FIFO retained. Then `rst_n` is asserted mid-read → all outputs are 0 and no later `rd_valid` occurs.

Source files
------------

// File: rtl/sram_access_arbiter_pkg.sv
// rtl/sram_access_arbiter_pkg.sv - shared widths, timing defaults and encodings for the SRAM access arbiter
package sram_access_arbiter_pkg;

  // Controller data word width.
  localparam int SRAM_WORD      = 256;
  // Cycles from read strobe to controller data valid.
  localparam int RD_LAT_DEF     = 3;
  // Minimum cycles from a read issue to the next controller access.
  localparam int RD_GAP_DEF     = 4;
  // Write-back FIFO entries (power of two).
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RSTA  = 2'd2
  } arb_state_e;

  typedef enum logic {
    TURN_RD = 1'b0,
    TURN_WR = 1'b1
  } turn_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } grant_e;

endpackage

// File: rtl/sram_wr_fifo.sv
// rtl/sram_wr_fifo.sv - synchronous write-back FIFO with wrap-bit full/empty flags
module sram_wr_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Equal pointers mean empty; equal index with differing wrap bit means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer advance; a pop on an empty FIFO only happens together with a push
  // (pass-through), so both pointers move and the FIFO stays empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the flags gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - read/write-back arbiter in front of the single-port SRAM controller
module sram_access_arbiter
  import sram_access_arbiter_pkg::*;
#(
  parameter int WORD       = SRAM_WORD,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int RD_GAP     = RD_GAP_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_req,
  output logic            rd_ready,
  output logic            rd_valid,
  output logic [WORD-1:0] rd_data,
  input  logic            wr_valid,
  input  logic [WORD-1:0] wr_data,
  output logic            wr_ready,
  input  logic            flush_req,
  output logic            flush_done,
  input  logic            i_busy,
  input  logic [WORD-1:0] i_request_data,
  output logic            o_PE_request,
  output logic            o_PE_send,
  output logic [WORD-1:0] o_send_data,
  output logic            o_rst_addr
);

  localparam int GAP_W = $clog2(RD_GAP + 1);

  arb_state_e        state, state_nxt;
  turn_e             turn;
  grant_e            gnt;
  logic [GAP_W-1:0]  gap;
  logic [RD_LAT-1:0] vld_sr;

  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD-1:0]   fifo_head;
  logic              wr_avail;
  logic [WORD-1:0]   wr_word;
  logic              slot;

  assign wr_ready = !fifo_full && (state == ST_RUN);
  assign push     = wr_valid && wr_ready;
  assign pop      = (gnt == GNT_WR);

  // A word offered into an empty FIFO is usable in the same slot, so a lone
  // write reaches the controller one cycle after it is accepted.
  assign wr_avail = !fifo_empty || push;
  assign wr_word  = fifo_empty ? wr_data : fifo_head;
  assign slot     = (gap == '0) && !i_busy;

  sram_wr_fifo #(
    .WIDTH (WORD),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Slot arbitration: full FIFO first, then the turn bit, then reads, then leftover writes.
  always_comb begin
    gnt = GNT_NONE;
    if (slot) begin
      if (fifo_full)                            gnt = GNT_WR;
      else if ((turn == TURN_WR) && wr_avail)   gnt = GNT_WR;
      else if (rd_req && (state == ST_RUN))     gnt = GNT_RD;
      else if (wr_avail)                        gnt = GNT_WR;
    end
  end

  assign rd_ready = (gnt == GNT_RD);

  // Read spacing counter and alternation bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap  <= '0;
      turn <= TURN_RD;
    end else begin
      if (gnt == GNT_RD)   gap <= GAP_W'(RD_GAP - 1);
      else if (gap != '0)  gap <= gap - 1'b1;
      if (gnt == GNT_RD)      turn <= TURN_WR;
      else if (gnt == GNT_WR) turn <= TURN_RD;
    end
  end

  // Registered controller strobes; write data is captured at issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_PE_request <= 1'b0;
      o_PE_send    <= 1'b0;
      o_send_data  <= '0;
    end else begin
      o_PE_request <= (gnt == GNT_RD);
      o_PE_send    <= (gnt == GNT_WR);
      if (gnt == GNT_WR) o_send_data <= wr_word;
    end
  end

  // Tracks in-flight reads so the unflagged controller data can be qualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_sr <= '0;
    else        vld_sr <= {vld_sr[RD_LAT-2:0], o_PE_request};
  end

  assign rd_valid = vld_sr[RD_LAT-1];
  assign rd_data  = rd_valid ? i_request_data : '0;

  // Pass-state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Flush sequencing: drain writes and in-flight reads, then strobe address reset once.
  always_comb begin
    state_nxt  = state;
    o_rst_addr = 1'b0;
    flush_done = 1'b0;
    case (state)
      ST_RUN: begin
        if (flush_req) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (fifo_empty && (gap == '0) && (vld_sr == '0) && !o_PE_request)
          state_nxt = ST_RSTA;
      end
      ST_RSTA: begin
        o_rst_addr = 1'b1;
        flush_done = 1'b1;
        state_nxt  = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - directed scoreboard bench for sram_access_arbiter
module tb_sram_access_arbiter;

  localparam int W      = 256;
  localparam int RD_LAT = 3;
  localparam int RD_GAP = 4;

  logic         clk;
  logic         rst_n;
  logic         rd_req;
  logic         rd_ready;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic         wr_valid;
  logic [W-1:0] wr_data;
  logic         wr_ready;
  logic         flush_req;
  logic         flush_done;
  logic         i_busy;
  logic [W-1:0] i_request_data;
  logic         o_PE_request;
  logic         o_PE_send;
  logic [W-1:0] o_send_data;
  logic         o_rst_addr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_req = 0, n_send = 0, n_strobe = 0, n_valid = 0, n_done = 0;
  int last_rd = 0;
  bit have_rd = 0;
  bit contend = 0;
  int prev_type = 0;

  int           rq[$];
  logic [W-1:0] wq[$];

  function automatic logic [W-1:0] pat(input int c);
    return {8{32'hC0DE_0000 ^ 32'(c)}};
  endfunction

  assign i_request_data = pat(cyc);

  sram_access_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_req         (rd_req),
    .rd_ready       (rd_ready),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .i_busy         (i_busy),
    .i_request_data (i_request_data),
    .o_PE_request   (o_PE_request),
    .o_PE_send      (o_PE_send),
    .o_send_data    (o_send_data),
    .o_rst_addr     (o_rst_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard / protocol monitor, sampled on the falling edge.
  initial begin
    int stype;
    int e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rd_req && rd_ready) rq.push_back(cyc + 1 + RD_LAT);
        if (wr_valid && wr_ready) wq.push_back(wr_data);
        if (o_PE_request || o_PE_send) begin
          n_strobe++;
          chk1("strobe_overlap", o_PE_request & o_PE_send, 1'b0);
          if (have_rd) chk1("read_gap", (cyc - last_rd) >= RD_GAP, 1'b1);
          if (contend) begin
            stype = o_PE_request ? 1 : 2;
            if (prev_type != 0) chk1("alternate", stype != prev_type, 1'b1);
            prev_type = stype;
          end
        end
        if (o_PE_request) begin
          have_rd = 1'b1;
          last_rd = cyc;
          n_req++;
        end
        if (o_PE_send) begin
          n_send++;
          if (wq.size() == 0) chk1("wr_spurious", o_PE_send, 1'b0);
          else chkw("wr_data", o_send_data, wq.pop_front());
        end
        if (rd_valid) begin
          n_valid++;
          if (rq.size() == 0) chk1("rd_spurious", rd_valid, 1'b0);
          else begin
            e = rq.pop_front();
            chki("rd_cycle", cyc, e);
            chkw("rd_data", rd_data, pat(e));
          end
        end
        if (o_rst_addr || flush_done) begin
          n_done += flush_done ? 1 : 0;
          chk1("rst_addr_with_done", o_rst_addr, flush_done);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, k, done_seen;
    int base_req, base_send, base_strobe, base_valid, base_done;

    rst_n = 1'b0; rd_req = 1'b0; wr_valid = 1'b0; wr_data = '0;
    flush_req = 1'b0; i_busy = 1'b0;
    tick(3);
    chk1("rst_rd_ready",     rd_ready,     1'b0);
    chk1("rst_rd_valid",     rd_valid,     1'b0);
    chkw("rst_rd_data",      rd_data,      '0);
    chk1("rst_wr_ready",     wr_ready,     1'b1);
    chk1("rst_flush_done",   flush_done,   1'b0);
    chk1("rst_o_PE_request", o_PE_request, 1'b0);
    chk1("rst_o_PE_send",    o_PE_send,    1'b0);
    chkw("rst_o_send_data",  o_send_data,  '0);
    chk1("rst_o_rst_addr",   o_rst_addr,   1'b0);
    rst_n = 1'b1;
    tick(1);

    // Read alone: one issue every RD_GAP cycles.
    base_req = n_req;
    rd_req = 1'b1;
    #1 chk1("rd_alone_ready", rd_ready, 1'b1);
    tick(12);
    rd_req = 1'b0;
    tick(8);
    chki("rd_alone_count", n_req - base_req, 3);
    chki("rd_alone_drained", rq.size(), 0);

    // Write burst into an empty FIFO: one send per cycle, first one cycle after push.
    base_send = n_send;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = pat(1000 + i);
      #1 chk1("burst_wr_ready", wr_ready, 1'b1);
      tick(1);
      chk1("burst_send", o_PE_send, 1'b1);
    end
    wr_valid = 1'b0;
    tick(3);
    chki("burst_count", n_send - base_send, 4);

    // Full priority: fill under busy, then a write must beat the pending read.
    i_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = pat(2000 + i);
      tick(1);
    end
    wr_valid = 1'b0;
    chk1("full_wr_ready", wr_ready, 1'b0);
    rd_req = 1'b1;
    i_busy = 1'b0;
    #1 chk1("full_rd_ready", rd_ready, 1'b0);
    tick(1);
    chk1("full_first_send", o_PE_send, 1'b1);
    chk1("full_first_req", o_PE_request, 1'b0);

    // Contention: reads and writes must alternate.
    contend = 1'b1;
    prev_type = 0;
    for (int i = 0; i < 24; i++) begin
      wr_valid = 1'b1;
      wr_data  = pat(3000 + i);
      tick(1);
    end
    contend = 1'b0;
    rd_req = 1'b0;
    wr_valid = 1'b0;
    tick(16);
    chki("contend_rd_drained", rq.size(), 0);
    chki("contend_wr_drained", wq.size(), 0);

    // Flush with one outstanding read and three queued writes.
    base_done = n_done;
    a = cyc;
    rd_req = 1'b1;
    #1 chk1("fl_rd_ready", rd_ready, 1'b1);
    tick(1);
    rd_req = 1'b0; wr_valid = 1'b1; wr_data = pat(4000);
    tick(1);
    wr_data = pat(4001);
    tick(1);
    wr_data = pat(4002); flush_req = 1'b1;
    tick(1);
    flush_req = 1'b0; wr_data = pat(4999); rd_req = 1'b1;
    done_seen = 0;
    k = 0;
    while (done_seen == 0 && k < 12) begin
      #1;
      chk1("fl_wr_ready", wr_ready, 1'b0);
      chk1("fl_rd_ready_blk", rd_ready, 1'b0);
      if (flush_done) begin
        chk1("fl_rst_addr", o_rst_addr, 1'b1);
        chki("fl_done_cycle", cyc, a + 8);
        done_seen = 1;
      end
      tick(1);
      k++;
    end
    rd_req = 1'b0;
    wr_valid = 1'b0;
    chki("fl_done_seen", done_seen, 1);
    tick(4);
    chki("fl_done_once", n_done - base_done, 1);
    chki("fl_rd_drained", rq.size(), 0);
    chki("fl_wr_drained", wq.size(), 0);

    // Busy stall keeps queued writes, which issue once busy drops.
    base_strobe = n_strobe;
    base_send = n_send;
    i_busy = 1'b1;
    wr_valid = 1'b1; wr_data = pat(5000);
    tick(1);
    wr_data = pat(5001);
    tick(1);
    wr_valid = 1'b0;
    tick(10);
    chki("busy_no_strobe", n_strobe - base_strobe, 0);
    i_busy = 1'b0;
    tick(4);
    chki("busy_sends", n_send - base_send, 2);

    // Reset while a read is in flight: nothing may come back.
    base_valid = n_valid;
    rd_req = 1'b1;
    #1 chk1("mid_rd_ready", rd_ready, 1'b1);
    tick(1);
    rd_req = 1'b0;
    chk1("mid_req_strobe", o_PE_request, 1'b1);
    tick(1);
    rst_n = 1'b0;
    rq.delete();
    wq.delete();
    have_rd = 1'b0;
    #1;
    chk1("mid_rst_rd_valid",     rd_valid,     1'b0);
    chkw("mid_rst_rd_data",      rd_data,      '0);
    chk1("mid_rst_rd_ready",     rd_ready,     1'b0);
    chk1("mid_rst_o_PE_request", o_PE_request, 1'b0);
    chk1("mid_rst_o_PE_send",    o_PE_send,    1'b0);
    chkw("mid_rst_o_send_data",  o_send_data,  '0);
    chk1("mid_rst_o_rst_addr",   o_rst_addr,   1'b0);
    chk1("mid_rst_flush_done",   flush_done,   1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(8);
    chki("mid_rst_no_valid", n_valid - base_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
